// File: rtl/day3_pkg.sv
// Shared constants, FSM encoding and byte-class record for the Day 3 front end.
package day3_pkg;
  localparam int DIGIT_W = 4;
  localparam int JOLT_W  = 8;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, SETTLE, WAIT, ACCUM, DONE} streamer_state_t;

  typedef struct packed {
    logic               is_digit;
    logic               is_eol;
    logic               is_skip;
    logic               is_bad;
    logic [DIGIT_W-1:0] value;
  } byte_class_t;
endpackage

// File: rtl/day3_ascii_class.sv
// Combinational ASCII byte classifier: digit / end-of-line / whitespace / illegal.
module day3_ascii_class
  import day3_pkg::*;
(
  input  logic [7:0]  ch,
  output byte_class_t cls
);
  always_comb begin
    cls = '0;
    if (ch >= ASCII_0 && ch <= ASCII_9) begin
      cls.is_digit = 1'b1;
      // '0'..'9' are 0x30..0x39, so the low nibble is the digit value
      cls.value    = ch[DIGIT_W-1:0];
    end else if (ch == ASCII_LF) begin
      cls.is_eol = 1'b1;
    end else if (ch == ASCII_CR || ch == ASCII_SP) begin
      cls.is_skip = 1'b1;
    end else begin
      cls.is_bad = 1'b1;
    end
  end
endmodule

// File: rtl/day3_bank_streamer.sv
// Splits the puzzle byte stream into per-bank digit streams for the solver and
// accumulates the solver's per-bank results into a puzzle total.
module day3_bank_streamer
  import day3_pkg::*;
#(
  parameter int TOTAL_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic               bank_clear,
  output logic [DIGIT_W-1:0] digit,
  output logic               digit_valid,
  input  logic [JOLT_W-1:0]  sol_result,
  output logic [TOTAL_W-1:0] total,
  output logic [CNT_W-1:0]   bank_count,
  output logic               err_char,
  output logic               err_short,
  output logic               done_
);
  streamer_state_t state, state_nxt;
  byte_class_t     cls;
  logic [7:0]      dcnt;
  logic            last_r;
  logic            accept, eob, blank;

  day3_ascii_class u_class (.ch(in_data), .cls(cls));

  assign in_ready   = (state == STREAM);
  assign bank_clear = (state == CLEAR);
  assign done_      = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign eob        = cls.is_eol || in_last;
  // a closing byte that is itself a digit still makes the bank non-empty
  assign blank      = (dcnt == 8'd0) && !cls.is_digit;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CLEAR;
      CLEAR:   state_nxt = STREAM;
      STREAM:  if (accept && eob) state_nxt = blank ? (in_last ? DONE : CLEAR) : SETTLE;
      SETTLE:  state_nxt = WAIT;
      WAIT:    state_nxt = ACCUM;
      ACCUM:   state_nxt = last_r ? DONE : CLEAR;
      DONE:    if (start) state_nxt = CLEAR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      digit       <= '0;
      digit_valid <= 1'b0;
      total       <= '0;
      bank_count  <= '0;
      err_char    <= 1'b0;
      err_short   <= 1'b0;
      dcnt        <= '0;
      last_r      <= 1'b0;
    end else begin
      state       <= state_nxt;
      digit_valid <= 1'b0;
      if ((state == IDLE || state == DONE) && start) begin
        total      <= '0;
        bank_count <= '0;
        err_char   <= 1'b0;
        err_short  <= 1'b0;
      end
      if (state == CLEAR) begin
        dcnt   <= '0;
        last_r <= 1'b0;
      end
      if (accept) begin
        case (1'b1)
          cls.is_digit: begin
            digit       <= cls.value;
            digit_valid <= 1'b1;
            if (dcnt != 8'hFF) dcnt <= dcnt + 8'd1;
          end
          cls.is_bad:              err_char <= 1'b1;
          cls.is_eol, cls.is_skip: ;
          default: ;
        endcase
        if (eob) last_r <= in_last;
      end
      // solver result has settled by ACCUM; single-digit banks only flag
      if (state == ACCUM) begin
        if (dcnt >= 8'd2) begin
          total      <= total + TOTAL_W'(sol_result);
          bank_count <= bank_count + CNT_W'(1);
        end else if (dcnt == 8'd1) begin
          err_short <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_day3_bank_streamer.sv
// Directed bench: behavioural max-pair solver, per-cycle digit/framing checks,
// and a string-level model of bank totals pinned by literal expectations.
module tb_day3_bank_streamer;
  import day3_pkg::*;

  logic        clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic        in_ready, bank_clear, digit_valid, err_char, err_short, done_;
  logic [3:0]  digit;
  logic [7:0]  sol_result;
  logic [31:0] total;
  logic [15:0] bank_count;

  always #5 clock = ~clock;

  day3_bank_streamer dut (
    .clock(clock), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .bank_clear(bank_clear), .digit(digit), .digit_valid(digit_valid),
    .sol_result(sol_result), .total(total), .bank_count(bank_count),
    .err_char(err_char), .err_short(err_short), .done_(done_)
  );

  int checks = 0, passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // solver stand-in: best ordered two-digit pair seen since the last clear
  int mx = 0, best = 0;
  bit seen = 0;
  always @(posedge clock) begin
    if (reset || bank_clear) begin
      seen <= 0; mx <= 0; best <= 0;
    end else if (digit_valid) begin
      if (seen && (mx * 10 + int'(digit)) > best) best <= mx * 10 + int'(digit);
      if (int'(digit) > mx) mx <= int'(digit);
      seen <= 1;
    end
  end
  assign sol_result = 8'(best);

  int exp_q[$];
  bit prev_clr = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (bank_clear) begin
        chk("clear_vs_digit_valid", digit_valid, 0);
        chk("clear_one_cycle", prev_clr, 0);
      end
      if (digit_valid) begin
        chk("digit_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("digit_value", digit, exp_q.pop_front());
      end
    end
    prev_clr <= bank_clear;
  end

  function automatic int maxpair(input int d[$]);
    int m = 0;
    for (int i = 0; i < d.size(); i++)
      for (int j = i + 1; j < d.size(); j++)
        if (d[i] * 10 + d[j] > m) m = d[i] * 10 + d[j];
    return m;
  endfunction

  task automatic model(input string s, output int tot, output int nb, output bit ec, output bit es);
    int d[$];
    logic [7:0] c;
    bit close;
    tot = 0; nb = 0; ec = 0; es = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      close = (i == s.len() - 1);
      if (c >= 8'h30 && c <= 8'h39) d.push_back(int'(c) - 48);
      else if (c == 8'h0A) close = 1;
      else if (c != 8'h0D && c != 8'h20) ec = 1;
      if (close) begin
        if (d.size() == 1) es = 1;
        else if (d.size() >= 2) begin tot += maxpair(d); nb++; end
        d.delete();
      end
    end
  endtask

  // caller is at a negedge; each byte is held until in_ready covers a posedge
  task automatic send(input string s, input int maxgap, input bit with_last);
    logic [7:0] c;
    int n;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (maxgap > 0) begin
        in_valid = 0; in_last = 0;
        repeat ($urandom_range(0, maxgap)) @(negedge clock);
      end
      in_data = c; in_valid = 1;
      in_last = with_last && (i == s.len() - 1);
      if (c >= 8'h30 && c <= 8'h39) exp_q.push_back(int'(c) - 48);
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) chk("in_ready_timeout", n, 0);
      @(negedge clock);
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic pulse_start(input string name);
    start = 1;
    @(negedge clock);
    start = 0;
    chk({name, "_done_dropped"}, done_, 0);
    chk({name, "_total_cleared"}, total, 0);
    chk({name, "_banks_cleared"}, bank_count, 0);
    chk({name, "_errs_cleared"}, {err_char, err_short}, 0);
  endtask

  task automatic run(input string name, input string s, input int maxgap,
                     input int lit_tot, input int lit_nb, input bit lit_ec, input bit lit_es);
    int mt, mb, c;
    bit mec, mes;
    model(s, mt, mb, mec, mes);
    chk({name, "_model_total"}, mt, lit_tot);
    chk({name, "_model_banks"}, mb, lit_nb);
    chk({name, "_model_errs"}, {mec, mes}, {lit_ec, lit_es});
    pulse_start(name);
    send(s, maxgap, 1);
    c = 0;
    while (!done_ && c < 200) begin @(negedge clock); c++; end
    // last close accepted in n: SETTLE, WAIT, ACCUM, then DONE in n+4
    chk({name, "_done_latency"}, c, 3);
    chk({name, "_done"}, done_, 1);
    chk({name, "_total"}, total, mt);
    chk({name, "_banks"}, bank_count, mb);
    chk({name, "_err_char"}, err_char, mec);
    chk({name, "_err_short"}, err_short, mes);
    chk({name, "_digits_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bank_clear", bank_clear, 0);
    chk("rst_digit", digit, 0);
    chk("rst_digit_valid", digit_valid, 0);
    chk("rst_total", total, 0);
    chk("rst_bank_count", bank_count, 0);
    chk("rst_errs", {err_char, err_short}, 0);
    chk("rst_done", done_, 0);
    reset = 0;
    @(negedge clock);

    run("aoc", "987654321111111\n811111111111119\n234234234234278\n818181911112111\n", 0, 357, 4, 0, 0);
    run("crlf", "12\r\n\n34", 0, 46, 2, 0, 0);
    run("short", "5\n99\n", 1, 99, 1, 0, 1);
    run("badch", "1x3\n", 0, 13, 1, 1, 0);

    pulse_start("abort");
    send("1234", 2, 0);
    @(negedge clock);
    #1;
    chk("abort_digits_drained", exp_q.size(), 0);
    reset = 1;
    @(negedge clock);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_total", total, 0);
    chk("abort_banks", bank_count, 0);
    reset = 0;
    @(negedge clock);

    run("restart", "91\n", 2, 91, 1, 0, 0);
    run("again", "19\n", 0, 19, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
